// File: rtl/cache_mem_arbiter_if.sv
// Bundle of cache-side request/fill signals and the shared memory word port.
// The master modport is the arbiter's view; slave is the caches/memory side.
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 3
);
    logic              icache_miss;
    logic [ADDR_W-1:0] icache_miss_addr;
    logic              dcache_miss;
    logic [ADDR_W-1:0] dcache_miss_addr;
    logic              dcache_wr;
    logic [ADDR_W-1:0] dcache_wr_addr;
    logic [DATA_W-1:0] dcache_wr_data;
    logic              mem_enable;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_data_valid;
    logic              icache_fill_we;
    logic              dcache_fill_we;
    logic [IDX_W-1:0]  fill_word_idx;
    logic [DATA_W-1:0] fill_data;
    logic              icache_fill_done;
    logic              dcache_fill_done;
    logic              wr_ack;
    logic              cache_stall;

    modport master (
        input  icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
               dcache_wr, dcache_wr_addr, dcache_wr_data, mem_data_out, mem_data_valid,
        output mem_enable, mem_wr, mem_addr, mem_data_in, icache_fill_we, dcache_fill_we,
               fill_word_idx, fill_data, icache_fill_done, dcache_fill_done, wr_ack, cache_stall
    );

    modport slave (
        output icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
               dcache_wr, dcache_wr_addr, dcache_wr_data, mem_data_out, mem_data_valid,
        input  mem_enable, mem_wr, mem_addr, mem_data_in, icache_fill_we, dcache_fill_we,
               fill_word_idx, fill_data, icache_fill_done, dcache_fill_done, wr_ack, cache_stall
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one pipelined memory word port between I-cache fills, D-cache fills
// and D-cache write-through stores; drives the global pipeline stall.
module cache_mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int MEM_LAT     = 4
) (
    input logic                clk,
    input logic                rst_n,
    cache_mem_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam int BYTES = DATA_W / 8;
    localparam int OFF   = $clog2(BLOCK_WORDS * BYTES);

    typedef enum logic [1:0] {IDLE, WRITE, FILL_I, FILL_D} state_t;

    state_t            state, nextState;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  issueCnt;
    logic [IDX_W-1:0]  retCnt;
    logic              issuing;

    function automatic logic [ADDR_W-1:0] blockAlign(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFF], {OFF{1'b0}}};
    endfunction

    assign issuing = (issueCnt < CNT_W'(BLOCK_WORDS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            base     <= '0;
            issueCnt <= '0;
            retCnt   <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE) begin
                issueCnt <= '0;
                retCnt   <= '0;
                if (nextState == FILL_D)
                    base <= blockAlign(bus.dcache_miss_addr);
                else if (nextState == FILL_I)
                    base <= blockAlign(bus.icache_miss_addr);
            end else if (state == FILL_I || state == FILL_D) begin
                if (issuing)
                    issueCnt <= issueCnt + CNT_W'(1);
                if (bus.mem_data_valid)
                    retCnt <= retCnt + IDX_W'(1);
            end
        end
    end

    always_comb begin
        nextState            = state;
        bus.mem_enable       = 1'b0;
        bus.mem_wr           = 1'b0;
        bus.mem_addr         = '0;
        bus.mem_data_in      = '0;
        bus.icache_fill_we   = 1'b0;
        bus.dcache_fill_we   = 1'b0;
        bus.fill_word_idx    = '0;
        bus.fill_data        = '0;
        bus.icache_fill_done = 1'b0;
        bus.dcache_fill_done = 1'b0;
        bus.wr_ack           = 1'b0;
        bus.cache_stall      = (state != IDLE) | bus.icache_miss | bus.dcache_miss | bus.dcache_wr;

        case (state)
            IDLE: begin
                if (bus.dcache_wr)
                    nextState = WRITE;
                else if (bus.dcache_miss)
                    nextState = FILL_D;
                else if (bus.icache_miss)
                    nextState = FILL_I;
            end
            WRITE: begin
                bus.mem_enable  = 1'b1;
                bus.mem_wr      = 1'b1;
                bus.mem_addr    = bus.dcache_wr_addr;
                bus.mem_data_in = bus.dcache_wr_data;
                bus.wr_ack      = 1'b1;
                nextState       = IDLE;
            end
            FILL_I, FILL_D: begin
                // Issue and return overlap: reads go out back-to-back while
                // earlier words are already coming back MEM_LAT cycles later.
                if (issuing) begin
                    bus.mem_enable = 1'b1;
                    bus.mem_addr   = base + ADDR_W'(issueCnt) * ADDR_W'(BYTES);
                end
                if (bus.mem_data_valid) begin
                    bus.fill_data     = bus.mem_data_out;
                    bus.fill_word_idx = retCnt;
                    if (state == FILL_I)
                        bus.icache_fill_we = 1'b1;
                    else
                        bus.dcache_fill_we = 1'b1;
                    if (retCnt == IDX_W'(BLOCK_WORDS - 1)) begin
                        bus.icache_fill_done = (state == FILL_I);
                        bus.dcache_fill_done = (state == FILL_D);
                        nextState            = IDLE;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sequences the single shared data memory between the instruction cache, the data cache and data-cache write-through stores.
- Sits between the two caches and the memory: one 16-bit word port, pipelined reads with fixed latency.
- Fills whole 16-byte blocks (8 words) on a cache miss and issues single-word stores.
- Drives the global cache_stall that freezes the pipeline while memory is busy.

Parameters:
ADDR_W, 16, byte address width
DATA_W, 16, word width
BLOCK_WORDS, 8, words per cache block (block = 16 bytes)
MEM_LAT, 4, cycles from a read issue to its mem_data_valid

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
icache_miss  in  1  I-cache requests a block fill; held until icache_fill_done
icache_miss_addr  in  ADDR_W  byte address of the missing instruction
dcache_miss  in  1  D-cache requests a block fill; held until dcache_fill_done
dcache_miss_addr  in  ADDR_W  byte address of the missing data
dcache_wr  in  1  write-through store request; held until wr_ack
dcache_wr_addr  in  ADDR_W  store byte address
dcache_wr_data  in  DATA_W  store data
mem_enable  out  1  memory access this cycle
mem_wr  out  1  memory write this cycle; 0 = read
mem_addr  out  ADDR_W  memory byte address
mem_data_in  out  DATA_W  write data to memory
mem_data_out  in  DATA_W  read data from memory
mem_data_valid  in  1  mem_data_out valid; arrives MEM_LAT cycles after each read issue
icache_fill_we  out  1  write fill_data into the I-cache block
dcache_fill_we  out  1  write fill_data into the D-cache block
fill_word_idx  out  3  word index within the block for fill_data
fill_data  out  DATA_W  returned word, equal to mem_data_out
icache_fill_done  out  1  one-cycle pulse with the last I-cache fill word
dcache_fill_done  out  1  one-cycle pulse with the last D-cache fill word
wr_ack  out  1  one-cycle pulse; store issued this cycle
cache_stall  out  1  pipeline freeze

Behaviour:
- **States:** IDLE, WRITE, FILL_I, FILL_D. Reset is asynchronous: state goes to IDLE, issue and return counters go to 0, and all outputs are 0 except cache_stall, which is combinational.
- **IDLE arbitration**, evaluated each cycle with fixed priority:
  - dcache_wr → WRITE.
  - else dcache_miss → FILL_D.
  - else icache_miss → FILL_I.
  - On entry, latch base = miss_addr with bits [3:0] cleared.
- **WRITE** (1 cycle): mem_enable=1, mem_wr=1, mem_addr=dcache_wr_addr, mem_data_in=dcache_wr_data, wr_ack=1. Next state is IDLE.
- **FILL_x issue phase:**
  - Issue counter k runs 0..7.
  - Each cycle with k<8: mem_enable=1, mem_wr=0, mem_addr = base + 2k, then k++.
  - mem_enable=0 once k=8.
- **FILL_x return phase:**
  - Each mem_data_valid cycle: fill_data=mem_data_out, fill_word_idx = return counter r, that cache's fill_we=1, then r++.
  - When r=7 is written, pulse fill_done and return to IDLE on the next edge.
  - Total fill = BLOCK_WORDS + MEM_LAT cycles (12 by default). done is asserted in the 12th cycle.
- **mem_data_valid outside FILL_x** is ignored: no fill_we is raised. The memory shares rst_n and discards in-flight reads on reset.
- **Requests during a fill or write** are not serviced: wr_ack and done stay low and requests wait. Arbitration resumes in the first IDLE cycle.
- **Requester handshake:** requesters deassert the cycle after their done/ack.
- **Simultaneous icache_miss and dcache_miss:** D is filled first, then I. The I request must still be held.
- **cache_stall** (combinational) = (state≠IDLE) | icache_miss | dcache_miss | dcache_wr.
- **Address arithmetic:** base+2k is computed modulo 2^ADDR_W. A block at 0xFFF0 issues 0xFFF0..0xFFFE with no wrap into the next block.
- **Reset mid-fill:** IDLE immediately, no done pulse, partial fill abandoned. The cache must invalidate the block on reset.

Test Plan:
- **Reset values:** rst_n low mid-FILL_D at fill word 3 → all outputs 0 immediately and state IDLE; the next dcache_miss restarts with mem_addr = base.
- **I-cache fill:** icache_miss, addr 0x0126 → mem_addr 0x0120,0x0122,…,0x012E on cycles 1–8; icache_fill_we on cycles 5–12 with idx 0..7; icache_fill_done in cycle 12; cache_stall high throughout.
- **Store:** dcache_wr, addr 0x4002, data 0xBEEF → one cycle with mem_enable=1, mem_wr=1, mem_addr=0x4002, mem_data_in=0xBEEF, wr_ack=1.
- **Priority:** dcache_wr, dcache_miss (0x2000) and icache_miss (0x0040) raised together → WRITE, then FILL_D for 0x2000–0x200E, then FILL_I for 0x0040–0x004E; dcache_fill_done precedes icache_fill_done.
- **Boundary:** dcache_miss at 0xFFFA → issue addresses 0xFFF0..0xFFFE only; a spurious mem_data_valid in IDLE produces no fill_we.
- **Request during fill:** dcache_wr raised at FILL_I word 2 → wr_ack low until the first IDLE cycle after icache_fill_done, then a single WRITE cycle.
